// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: bus placement, register
// offsets, vector word layout and default source count.
package intc_pkg;

    localparam logic [31:0] INTC_BASE     = 32'h0000_7F50;
    localparam logic [31:0] INTC_LAST     = 32'h0000_7F6F;
    localparam int unsigned VALID_BIT     = 31;
    localparam int unsigned N_SRC_DEFAULT = 6;

    // Word offsets as seen on t_addr[4:2]
    typedef enum logic [2:0] {
        REG_MASK   = 3'd0,
        REG_MODE   = 3'd1,
        REG_PEND   = 3'd2,
        REG_VECTOR = 3'd3,
        REG_ACK    = 3'd4,
        REG_EOI    = 3'd5,
        REG_ISR    = 3'd6,
        REG_RSVD   = 3'd7
    } intc_reg_e;

    function automatic logic [31:0] vector_word(input logic valid, input logic [2:0] idx);
        logic [31:0] w;
        w = '0;
        if (valid) begin
            w[VALID_BIT] = 1'b1;
            w[2:0]       = idx;
        end
        return w;
    endfunction

endpackage

// File: rtl/intc_if.sv
// Bridge-side register bus of the interrupt controller.
interface intc_if;

    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output sel, output we, output addr, output wd, input rd);
    modport slave  (input sel, input we, input addr, input wd, output rd);

endinterface

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module intc_prio_enc #(
    parameter int unsigned N = 6
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx,
    output logic         valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Scan downward so the lowest set index is the last one written
        for (int unsigned i = N; i > 0; i--) begin
            if (req[i-1]) begin
                idx = 3'(i - 1);
            end
        end
    end

endmodule

// File: rtl/intc.sv
// Memory-mapped interrupt controller: edge/level latching, masking, fixed
// priority with in-service nesting, and a registered irq to CP0.
module intc
    import intc_pkg::*;
#(
    parameter int unsigned N_SRC = N_SRC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    intc_if.slave            bus,
    input  logic [N_SRC-1:0] src,
    output logic             irq
);

    logic [N_SRC-1:0] mask_q,   mask_d;
    logic [N_SRC-1:0] mode_q,   mode_d;
    logic [N_SRC-1:0] elatch_q, elatch_d;
    logic [N_SRC-1:0] isr_q,    isr_d;
    logic [N_SRC-1:0] src_q,    src_d;
    logic             irq_q,    irq_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend_eff;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] vec_oh;
    logic [N_SRC-1:0] isr_oh;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] wd_src;
    logic [2:0]       vec_idx;
    logic             vec_valid;
    logic [2:0]       isr_idx;
    logic             isr_valid;
    logic [3:0]       hi_isr;
    logic             wr;
    intc_reg_e        reg_sel;
    logic             unused_wd;

    assign wr        = bus.sel & bus.we;
    assign reg_sel   = intc_reg_e'(bus.addr);
    assign wd_src    = bus.wd[N_SRC-1:0];
    assign unused_wd = ^bus.wd;
    assign rise      = src & ~src_q;
    assign hi_isr    = isr_valid ? {1'b0, isr_idx} : 4'(N_SRC);

    intc_prio_enc #(.N(N_SRC)) u_vec_enc (
        .req   (eligible),
        .idx   (vec_idx),
        .valid (vec_valid)
    );

    intc_prio_enc #(.N(N_SRC)) u_isr_enc (
        .req   (isr_q),
        .idx   (isr_idx),
        .valid (isr_valid)
    );

    always_comb begin
        pend_eff = '0;
        eligible = '0;
        vec_oh   = '0;
        isr_oh   = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            pend_eff[i] = mode_q[i] ? elatch_q[i] : src_q[i];
            eligible[i] = pend_eff[i] & mask_q[i] & (4'(i) < hi_isr);
            vec_oh[i]   = vec_valid & (vec_idx == 3'(i));
            isr_oh[i]   = isr_valid & (isr_idx == 3'(i));
        end
    end

    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        isr_d  = isr_q;
        clr    = '0;
        if (wr) begin
            unique case (reg_sel)
                REG_MASK: mask_d = wd_src;
                REG_MODE: mode_d = wd_src;
                REG_PEND: clr    = wd_src;
                REG_ACK: begin
                    clr   = vec_oh;
                    isr_d = isr_q | vec_oh;
                end
                REG_EOI:  isr_d  = isr_q & ~isr_oh;
                default: ;
            endcase
        end
        // A new edge outranks any clear; masking with mode_d drops latches of
        // sources switched to level and lets a same-edge MODE write catch an edge
        elatch_d = ((elatch_q & ~clr) | rise) & mode_d;
        src_d    = src;
        irq_d    = |eligible;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= '0;
            mode_q   <= '0;
            elatch_q <= '0;
            isr_q    <= '0;
            src_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            elatch_q <= elatch_d;
            isr_q    <= isr_d;
            src_q    <= src_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        bus.rd = '0;
        unique case (reg_sel)
            REG_MASK:   bus.rd[N_SRC-1:0] = mask_q;
            REG_MODE:   bus.rd[N_SRC-1:0] = mode_q;
            REG_PEND:   bus.rd[N_SRC-1:0] = pend_eff;
            REG_VECTOR: bus.rd            = vector_word(vec_valid, vec_idx);
            REG_ISR:    bus.rd[N_SRC-1:0] = isr_q;
            default:    bus.rd            = '0;
        endcase
    end

endmodule

// File: tb/tb_intc.sv
// Directed self-checking bench for intc with hand-computed expectations.
module tb_intc;
    import intc_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] src;
    logic       irq;
    int         n_tests;
    int         n_fail;

    intc_if bus();

    intc #(.N_SRC(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .src   (src),
        .irq   (irq)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sel  = 1'b1;
        bus.we   = 1'b1;
        bus.addr = a;
        bus.wd   = d;
        @(posedge clk);
        #1;
        bus.sel = 1'b0;
        bus.we  = 1'b0;
        bus.wd  = '0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(tag, bus.rd, exp);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        src      = '0;
        bus.sel  = 1'b0;
        bus.we   = 1'b0;
        bus.addr = '0;
        bus.wd   = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        rd_check("rst_mask", REG_MASK, 32'h0);
        rd_check("rst_pend", REG_PEND, 32'h0);
        rd_check("rst_vec",  REG_VECTOR, 32'h0);
        rd_check("rst_isr",  REG_ISR, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // Edge path on src0
        bus_write(REG_MASK, 32'h01);
        bus_write(REG_MODE, 32'h01);
        src = 6'b000001;
        tick();
        src = '0;
        rd_check("edge_pend_e1", REG_PEND, 32'h01);
        check("edge_irq_e1", {31'b0, irq}, 32'h0);
        tick();
        check("edge_irq_e2", {31'b0, irq}, 32'h1);
        rd_check("edge_vec", REG_VECTOR, 32'h8000_0000);
        bus_write(REG_PEND, 32'h01);
        rd_check("edge_w1c", REG_PEND, 32'h0);
        tick();
        check("edge_irq_clr", {31'b0, irq}, 32'h0);

        // Priority between src0 and src3
        bus_write(REG_MASK, 32'h09);
        bus_write(REG_MODE, 32'h09);
        src = 6'b001001;
        tick();
        src = '0;
        tick();
        rd_check("prio_vec", REG_VECTOR, 32'h8000_0000);
        check("prio_irq", {31'b0, irq}, 32'h1);
        bus_write(REG_ACK, 32'h0);
        rd_check("prio_ack_isr", REG_ISR, 32'h01);
        rd_check("prio_ack_pend", REG_PEND, 32'h08);
        rd_check("prio_ack_vec", REG_VECTOR, 32'h0);
        tick();
        check("prio_ack_irq", {31'b0, irq}, 32'h0);
        bus_write(REG_EOI, 32'h0);
        rd_check("prio_eoi_isr", REG_ISR, 32'h0);
        rd_check("prio_eoi_vec", REG_VECTOR, 32'h8000_0003);
        tick();
        check("prio_eoi_irq", {31'b0, irq}, 32'h1);

        // Nesting: service src3, then src1 preempts
        bus_write(REG_ACK, 32'h0);
        rd_check("nest_isr3", REG_ISR, 32'h08);
        bus_write(REG_MASK, 32'h0A);
        bus_write(REG_MODE, 32'h0A);
        src = 6'b000010;
        tick();
        src = '0;
        tick();
        check("nest_irq", {31'b0, irq}, 32'h1);
        rd_check("nest_vec", REG_VECTOR, 32'h8000_0001);
        bus_write(REG_ACK, 32'h0);
        rd_check("nest_ack_isr", REG_ISR, 32'h0A);
        bus_write(REG_EOI, 32'h0);
        rd_check("nest_eoi_isr", REG_ISR, 32'h08);
        tick();
        check("nest_eoi_irq", {31'b0, irq}, 32'h0);
        bus_write(REG_EOI, 32'h0);
        rd_check("nest_eoi2_isr", REG_ISR, 32'h0);

        // Level source src2
        bus_write(REG_MODE, 32'h00);
        bus_write(REG_MASK, 32'h04);
        src = 6'b000100;
        tick();
        rd_check("lvl_pend", REG_PEND, 32'h04);
        tick();
        check("lvl_irq", {31'b0, irq}, 32'h1);
        rd_check("lvl_vec", REG_VECTOR, 32'h8000_0002);
        bus_write(REG_ACK, 32'h0);
        rd_check("lvl_ack_isr", REG_ISR, 32'h04);
        rd_check("lvl_ack_pend", REG_PEND, 32'h04);
        tick();
        check("lvl_ack_irq", {31'b0, irq}, 32'h0);
        src = '0;
        tick();
        bus_write(REG_EOI, 32'h0);
        rd_check("lvl_eoi_pend", REG_PEND, 32'h0);
        rd_check("lvl_eoi_isr", REG_ISR, 32'h0);
        tick();
        check("lvl_eoi_irq", {31'b0, irq}, 32'h0);

        // Collision: new edge beats a same-edge W1C
        bus_write(REG_MODE, 32'h01);
        bus_write(REG_MASK, 32'h01);
        src = 6'b000001;
        tick();
        src = '0;
        tick();
        src = 6'b000001;
        bus_write(REG_PEND, 32'h01);
        rd_check("coll_pend_kept", REG_PEND, 32'h01);
        src = '0;
        bus_write(REG_PEND, 32'h01);
        rd_check("coll_pend_clr", REG_PEND, 32'h0);

        // Reset mid-service
        bus_write(REG_MODE, 32'h08);
        bus_write(REG_MASK, 32'h3F);
        src = 6'b001000;
        tick();
        src = '0;
        tick();
        rd_check("rs_vec3", REG_VECTOR, 32'h8000_0003);
        bus_write(REG_ACK, 32'h0);
        src = 6'b010001;
        tick();
        tick();
        rd_check("rs_isr", REG_ISR, 32'h08);
        check("rs_irq_pre", {31'b0, irq}, 32'h1);
        src = 6'b010000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_irq", {31'b0, irq}, 32'h0);
        for (int unsigned a = 0; a < 8; a++) begin
            rd_check($sformatf("rs_rd%0d", a), 3'(a), 32'h0);
        end
        bus_write(REG_MODE, 32'h10);
        rd_check("rs_elatch4", REG_PEND, 32'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
